// File: rtl/argon_pkg.sv
// Shared writeback types, widths and the register one-hot helper for the argon
// register-file write path.
package argon_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    // x0 never appears in the mask, so decode never stalls on it
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic valid,
                                                      input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] mask_s;
        mask_s = {NUM_REGS{1'b0}};
        if (valid && (rd != {REG_ADDR_W{1'b0}})) begin
            mask_s[rd] = 1'b1;
        end else begin
            mask_s = {NUM_REGS{1'b0}};
        end
        return mask_s;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback handshake bundle between the ALU/LSU producers, the register-file
// write port and the decode hazard logic.
interface rf_write_arbiter_if;
    import argon_pkg::*;

    logic                  i_alu_valid;
    logic                  o_alu_ready;
    logic [REG_ADDR_W-1:0] i_alu_rd;
    logic [XLEN-1:0]       i_alu_data;

    logic                  i_lsu_valid;
    logic                  o_lsu_ready;
    logic [REG_ADDR_W-1:0] i_lsu_rd;
    logic [XLEN-1:0]       i_lsu_data;

    logic                  o_rf_write_en;
    logic [REG_ADDR_W-1:0] o_rf_selectW;
    logic [XLEN-1:0]       o_rf_portW;
    logic [NUM_REGS-1:0]   o_pending;
    logic                  o_busy;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  o_alu_ready, o_lsu_ready,
        input  o_rf_write_en, o_rf_selectW, o_rf_portW, o_pending, o_busy
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
        output o_alu_ready, o_lsu_ready,
        output o_rf_write_en, o_rf_selectW, o_rf_portW, o_pending, o_busy
    );

endinterface

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; writes to x0 are swallowed at the door and
// never occupy the slot.
module wb_slot
    import argon_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_load,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [XLEN-1:0]       i_data,
    input  logic                  i_drain,
    output wb_req_t               o_slot,
    output wb_req_t               o_slot_next,
    output logic                  o_fill
);

    wb_req_t slot_r;
    wb_req_t slot_next_s;
    logic    fill_s;

    // Next occupancy: a fill wins over a drain so the slot refills in the cycle it empties
    always_comb begin
        slot_next_s = slot_r;
        fill_s      = i_load && (i_rd != {REG_ADDR_W{1'b0}});
        if (fill_s) begin
            slot_next_s = '{valid: 1'b1, rd: i_rd, data: i_data};
        end else if (i_drain) begin
            slot_next_s.valid = 1'b0;
        end else begin
            slot_next_s = slot_r;
        end
    end

    // Slot storage with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            slot_r <= '{valid: 1'b0, rd: {REG_ADDR_W{1'b0}}, data: {XLEN{1'b0}}};
        end else begin
            slot_r <= slot_next_s;
        end
    end

    assign o_slot      = slot_r;
    assign o_slot_next = slot_next_s;
    assign o_fill      = fill_s;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback slots.
// Define ARGON_WB_RR_EN for round-robin; otherwise fixed LSU priority with ALU starvation guard.
module rf_write_arbiter
    import argon_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    rf_write_arbiter_if.slave wb
);

    wb_req_t alu_slot_s;
    wb_req_t lsu_slot_s;
    wb_req_t alu_next_s;
    wb_req_t lsu_next_s;
    wb_req_t grant_entry_s;
    logic    alu_fill_s;
    logic    lsu_fill_s;
    logic    alu_ready_s;
    logic    lsu_ready_s;
    logic    grant_alu_s;
    logic    grant_lsu_s;
    logic    any_grant_s;
    logic    both_valid_s;
    wb_src_e older_r;

    logic [NUM_REGS-1:0]   pending_next_s;
    logic                  busy_next_s;
    logic                  rf_write_en_r;
    logic [REG_ADDR_W-1:0] rf_select_r;
    logic [XLEN-1:0]       rf_data_r;
    logic [NUM_REGS-1:0]   pending_r;
    logic                  busy_r;

`ifdef ARGON_WB_RR_EN
    wb_src_e rr_ptr_r;
`else
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt_r;
`endif

    // Grant depends only on registered state, so ready never combines with valid
    assign alu_ready_s    = !i_reset_n || !alu_slot_s.valid || grant_alu_s;
    assign lsu_ready_s    = !i_reset_n || !lsu_slot_s.valid || grant_lsu_s;
    assign any_grant_s    = grant_alu_s || grant_lsu_s;
    assign both_valid_s   = alu_slot_s.valid && lsu_slot_s.valid;

    wb_slot u_alu_slot (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (wb.i_alu_valid && alu_ready_s),
        .i_rd        (wb.i_alu_rd),
        .i_data      (wb.i_alu_data),
        .i_drain     (grant_alu_s),
        .o_slot      (alu_slot_s),
        .o_slot_next (alu_next_s),
        .o_fill      (alu_fill_s)
    );

    wb_slot u_lsu_slot (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (wb.i_lsu_valid && lsu_ready_s),
        .i_rd        (wb.i_lsu_rd),
        .i_data      (wb.i_lsu_data),
        .i_drain     (grant_lsu_s),
        .o_slot      (lsu_slot_s),
        .o_slot_next (lsu_next_s),
        .o_fill      (lsu_fill_s)
    );

    // Pick at most one slot: same-rd entries drain oldest first, otherwise the policy decides
    always_comb begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (both_valid_s) begin
            if (alu_slot_s.rd == lsu_slot_s.rd) begin
                grant_alu_s = (older_r == WB_SRC_ALU);
                grant_lsu_s = (older_r == WB_SRC_LSU);
            end else begin
`ifdef ARGON_WB_RR_EN
                grant_alu_s = (rr_ptr_r == WB_SRC_ALU);
                grant_lsu_s = (rr_ptr_r == WB_SRC_LSU);
`else
                grant_alu_s = (starve_cnt_r == STARVE_MAX);
                grant_lsu_s = (starve_cnt_r != STARVE_MAX);
`endif
            end
        end else if (alu_slot_s.valid) begin
            grant_alu_s = 1'b1;
        end else if (lsu_slot_s.valid) begin
            grant_lsu_s = 1'b1;
        end else begin
            grant_alu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end
    end

    // Payload of the granted slot heading to the output stage
    always_comb begin
        grant_entry_s = lsu_slot_s;
        if (grant_alu_s) begin
            grant_entry_s = alu_slot_s;
        end else begin
            grant_entry_s = lsu_slot_s;
        end
    end

    // Age flag: a fresh ALU entry is younger than whatever the LSU slot holds, ties included
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            older_r <= WB_SRC_LSU;
        end else if (alu_fill_s) begin
            older_r <= WB_SRC_LSU;
        end else if (lsu_fill_s) begin
            older_r <= WB_SRC_ALU;
        end
    end

`ifdef ARGON_WB_RR_EN
    // Round-robin pointer names the source favoured on the next contended cycle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rr_ptr_r <= WB_SRC_LSU;
        end else if (both_valid_s) begin
            rr_ptr_r <= grant_alu_s ? WB_SRC_LSU : WB_SRC_ALU;
        end
    end
`else
    // Saturating count of consecutive ALU losses; reaching the limit forces an ALU grant
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (alu_slot_s.valid && !grant_alu_s) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end
`endif

    // Hazard mask and busy reflect the state that will exist after this edge
    always_comb begin
        pending_next_s = rd_onehot(alu_next_s.valid, alu_next_s.rd)
                       | rd_onehot(lsu_next_s.valid, lsu_next_s.rd)
                       | rd_onehot(any_grant_s, grant_entry_s.rd);
        busy_next_s    = alu_next_s.valid || lsu_next_s.valid || any_grant_s;
    end

    // Registered write command; select/data hold their last value when idle
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rf_write_en_r <= 1'b0;
            rf_select_r   <= {REG_ADDR_W{1'b0}};
            rf_data_r     <= {XLEN{1'b0}};
            pending_r     <= {NUM_REGS{1'b0}};
            busy_r        <= 1'b0;
        end else begin
            rf_write_en_r <= any_grant_s;
            pending_r     <= pending_next_s;
            busy_r        <= busy_next_s;
            if (any_grant_s) begin
                rf_select_r <= grant_entry_s.rd;
                rf_data_r   <= grant_entry_s.data;
            end
        end
    end

    assign wb.o_alu_ready   = alu_ready_s;
    assign wb.o_lsu_ready   = lsu_ready_s;
    assign wb.o_rf_write_en = rf_write_en_r;
    assign wb.o_rf_selectW  = rf_select_r;
    assign wb.o_rf_portW    = rf_data_r;
    assign wb.o_pending     = pending_r;
    assign wb.o_busy        = busy_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: timestamp-based reference model compared
// every cycle, directed scenarios pinned with literal expectations, then random traffic.
module tb_rf_write_arbiter;
    import argon_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .wb        (bus)
    );

    typedef struct {
        bit          v;
        int          rd;
        logic [31:0] d;
        longint      ts;
    } ent_t;

    ent_t        m_alu;
    ent_t        m_lsu;
    bit          m_en;
    int          m_sel;
    logic [31:0] m_data;
    int          m_losses;
    bit          m_rr_lsu;
    longint      cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wr_sel[$];

`ifdef ARGON_WB_RR_EN
    int exp_sel[10] = '{4, 3, 4, 3, 4, 3, 4, 3, 4, 3};
`else
    int exp_sel[10] = '{4, 4, 4, 4, 3, 4, 4, 4, 4, 3};
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0 = none, 1 = ALU, 2 = LSU
    function automatic int m_grant();
        if (m_alu.v && m_lsu.v) begin
            if (m_alu.rd == m_lsu.rd) return (m_lsu.ts <= m_alu.ts) ? 2 : 1;
`ifdef ARGON_WB_RR_EN
            return m_rr_lsu ? 2 : 1;
`else
            return (m_losses >= LIMIT) ? 1 : 2;
`endif
        end
        if (m_alu.v) return 1;
        if (m_lsu.v) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p = 32'h0;
        if (m_alu.v) p[m_alu.rd] = 1'b1;
        if (m_lsu.v) p[m_lsu.rd] = 1'b1;
        if (m_en) p[m_sel] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        m_alu    = '{v: 1'b0, rd: 0, d: 32'h0, ts: 0};
        m_lsu    = '{v: 1'b0, rd: 0, d: 32'h0, ts: 0};
        m_en     = 1'b0;
        m_sel    = 0;
        m_data   = 32'h0;
        m_losses = 0;
        m_rr_lsu = 1'b1;
    endtask

    task automatic model_step();
        int g;
        bit acc_a;
        bit acc_l;
        if (!rst_n) begin
            model_reset();
        end else begin
            g     = m_grant();
            acc_a = bus.i_alu_valid && (!m_alu.v || g == 1);
            acc_l = bus.i_lsu_valid && (!m_lsu.v || g == 2);
            m_en  = (g != 0);
            if (g == 1) begin m_sel = m_alu.rd; m_data = m_alu.d; end
            if (g == 2) begin m_sel = m_lsu.rd; m_data = m_lsu.d; end
            if (m_alu.v && g != 1) m_losses++;
            else m_losses = 0;
            if (m_alu.v && m_lsu.v) m_rr_lsu = (g == 1);
            if (g == 1) m_alu.v = 1'b0;
            if (g == 2) m_lsu.v = 1'b0;
            if (acc_a && bus.i_alu_rd != 5'd0)
                m_alu = '{v: 1'b1, rd: int'(bus.i_alu_rd), d: bus.i_alu_data, ts: cyc};
            if (acc_l && bus.i_lsu_rd != 5'd0)
                m_lsu = '{v: 1'b1, rd: int'(bus.i_lsu_rd), d: bus.i_lsu_data, ts: cyc};
        end
        cyc++;
    endtask

    task automatic compare();
        bit busy_e;
        busy_e = m_alu.v || m_lsu.v || m_en;
        chk("alu_ready", 64'(bus.o_alu_ready), 64'(!rst_n || !m_alu.v || m_grant() == 1));
        chk("lsu_ready", 64'(bus.o_lsu_ready), 64'(!rst_n || !m_lsu.v || m_grant() == 2));
        chk("write_en", 64'(bus.o_rf_write_en), 64'(m_en));
        chk("selectW", 64'(bus.o_rf_selectW), 64'(m_sel));
        chk("portW", 64'(bus.o_rf_portW), 64'(m_data));
        chk("pending", 64'(bus.o_pending), 64'(m_pending()));
        chk("busy", 64'(bus.o_busy), 64'(busy_e));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit av, input int ard, input logic [31:0] ad,
                         input bit lv, input int lrd, input logic [31:0] ld);
        bus.i_alu_valid = av;
        bus.i_alu_rd    = 5'(ard);
        bus.i_alu_data  = ad;
        bus.i_lsu_valid = lv;
        bus.i_lsu_rd    = 5'(lrd);
        bus.i_lsu_data  = ld;
    endtask

    task automatic idle();
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        drive(1'b1, 3, 32'h1234, 1'b1, 4, 32'h5678);
        step();
        step();
        chk("rst_en", 64'(bus.o_rf_write_en), 64'd0);
        chk("rst_pending", 64'(bus.o_pending), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_portW", 64'(bus.o_rf_portW), 64'd0);
        chk("rst_alu_ready", 64'(bus.o_alu_ready), 64'd1);
        rst_n = 1'b1;
        idle();
        #1;
        chk("post_rst_alu_ready", 64'(bus.o_alu_ready), 64'd1);
        chk("post_rst_lsu_ready", 64'(bus.o_lsu_ready), 64'd1);
        chk("post_rst_pending", 64'(bus.o_pending), 64'd0);

        // single ALU write to r5
        drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
        step();
        idle();
        chk("alu5_pending_a", 64'(bus.o_pending), 64'h20);
        chk("alu5_en_early", 64'(bus.o_rf_write_en), 64'd0);
        step();
        chk("alu5_en", 64'(bus.o_rf_write_en), 64'd1);
        chk("alu5_sel", 64'(bus.o_rf_selectW), 64'd5);
        chk("alu5_data", 64'(bus.o_rf_portW), 64'hDEADBEEF);
        chk("alu5_pending_b", 64'(bus.o_pending), 64'h20);
        step();
        chk("alu5_en_off", 64'(bus.o_rf_write_en), 64'd0);
        chk("alu5_pending_clr", 64'(bus.o_pending), 64'd0);

        // contention from a clean reset: ALU r3 vs LSU r4 every cycle
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 3, 32'hA000 + 32'(i), 1'b1, 4, 32'hB000 + 32'(i));
            step();
            if (bus.o_rf_write_en) wr_sel.push_back(int'(bus.o_rf_selectW));
        end
        idle();
        chk("contend_count", 64'(wr_sel.size()), 64'd10);
        for (int i = 0; i < 10 && i < wr_sel.size(); i++) begin
            chk($sformatf("contend_sel%0d", i), 64'(wr_sel[i]), 64'(exp_sel[i]));
        end
        for (int i = 0; i < 4; i++) step();

        // WAW: LSU r7 then ALU r7 a cycle later
        drive(1'b0, 0, 32'h0, 1'b1, 7, 32'h11);
        step();
        drive(1'b1, 7, 32'h22, 1'b0, 0, 32'h0);
        step();
        idle();
        chk("waw_first", 64'(bus.o_rf_portW), 64'h11);
        step();
        chk("waw_second", 64'(bus.o_rf_portW), 64'h22);
        step();
        chk("waw_done", 64'(bus.o_rf_write_en), 64'd0);

        // WAW with same-cycle acceptance: LSU is older
        drive(1'b1, 7, 32'h44, 1'b1, 7, 32'h33);
        step();
        idle();
        step();
        chk("waw_same_first", 64'(bus.o_rf_portW), 64'h33);
        step();
        chk("waw_same_second", 64'(bus.o_rf_portW), 64'h44);
        step();

        // older ALU entry beats a younger LSU entry to the same rd
        drive(1'b1, 7, 32'hA1, 1'b1, 9, 32'hB9);
        step();
        drive(1'b0, 0, 32'h0, 1'b1, 7, 32'hB7);
        step();
        idle();
        chk("age_w1_sel", 64'(bus.o_rf_selectW), 64'd9);
        step();
        chk("age_w2_data", 64'(bus.o_rf_portW), 64'hA1);
        step();
        chk("age_w3_data", 64'(bus.o_rf_portW), 64'hB7);
        step();

        // x0 discard
        drive(1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0);
        step();
        chk("x0_pending", 64'(bus.o_pending), 64'd0);
        chk("x0_ready", 64'(bus.o_alu_ready), 64'd1);
        idle();
        step();
        chk("x0_no_write", 64'(bus.o_rf_write_en), 64'd0);
        chk("x0_busy", 64'(bus.o_busy), 64'd0);

        // reset while both slots and the output stage are full
        drive(1'b1, 10, 32'hC10, 1'b1, 11, 32'hC11);
        step();
        drive(1'b1, 12, 32'hC12, 1'b1, 13, 32'hC13);
        step();
        chk("mid_busy_before", 64'(bus.o_busy), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        chk("mid_rst_en", 64'(bus.o_rf_write_en), 64'd0);
        chk("mid_rst_pending", 64'(bus.o_pending), 64'd0);
        chk("mid_rst_busy", 64'(bus.o_busy), 64'd0);
        step();
        chk("mid_rst_no_stale", 64'(bus.o_rf_write_en), 64'd0);

        // random traffic with small rd range for frequent collisions and x0
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 9) < 6, int'($urandom_range(0, 7)), $urandom());
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
